// File: rtl/ibuf_deglitch_edge.sv
// ---------------------------------------------------------------------------
// ibuf_deglitch_edge
//   Synchronizes an asynchronous pad level (IBUF/IBUFG wrapper output) into
//   clk, rejects pulses shorter than filt_len+1 cycles and produces a clean
//   level, one-cycle rise/fall strobes and a rising-edge event counter.
//
// Parameters
//   SYNC_STAGES  synchronizer flop count (2..4)
//   FILTER_BITS  width of filt_len and the stability counter
//   CNT_WIDTH    width of edge_cnt / glitch_cnt
//   INIT_LEVEL   reset value of the synchronizer chain and dout
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   din          raw asynchronous pad level
//   en           1 = filter active, 0 = hold dout and suppress strobes
//   filt_len     extra stable cycles required before dout follows
//   cnt_clr      synchronous clear of edge_cnt and glitch_cnt
//   dout         filtered level
//   rise, fall   one-cycle strobes coincident with the dout change
//   edge_cnt     rise count, wraps
//   glitch_cnt   saturating glitch count
//
// Build option
//   IBUF_DEGLITCH_GLITCH_CNT_EN  defined: glitch_cnt is live;
//                                undefined: glitch_cnt is tied to zero.
// ---------------------------------------------------------------------------
module ibuf_deglitch_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_BITS = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din,
    input  logic                   en,
    input  logic [FILTER_BITS-1:0] filt_len,
    input  logic                   cnt_clr,
    output logic                   dout,
    output logic                   rise,
    output logic                   fall,
    output logic [CNT_WIDTH-1:0]   edge_cnt,
    output logic [CNT_WIDTH-1:0]   glitch_cnt
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [FILTER_BITS-1:0] stab_cnt;
    logic [FILTER_BITS-1:0] stab_nxt;
    logic                   dout_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic [CNT_WIDTH-1:0]   edge_nxt;

    // Synchronizer runs independently of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // stab_cnt counts the mismatch cycles already seen; the '>=' compare
    // against the live filt_len lets a lowered threshold act immediately.
    always_comb begin
        stab_nxt = '0;
        dout_nxt = dout;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (en && (sync_q != dout)) begin
            if (stab_cnt >= filt_len) begin
                dout_nxt = sync_q;
                rise_nxt = sync_q;
                fall_nxt = ~sync_q;
            end else begin
                stab_nxt = stab_cnt + FILTER_BITS'(1);
            end
        end
    end

    // Counter advances together with the registered rise strobe.
    always_comb begin
        edge_nxt = edge_cnt;
        if (cnt_clr) begin
            edge_nxt = '0;
        end else if (rise_nxt) begin
            edge_nxt = edge_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= INIT_LEVEL;
            rise     <= 1'b0;
            fall     <= 1'b0;
            stab_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            dout     <= dout_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            stab_cnt <= stab_nxt;
            edge_cnt <= edge_nxt;
        end
    end

`ifdef IBUF_DEGLITCH_GLITCH_CNT_EN
    // A glitch is the input returning to dout before the threshold was met.
    logic glitch_evt;

    assign glitch_evt = en && (sync_q == dout) && (stab_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (cnt_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign glitch_cnt = '0;
`endif

endmodule
